lock_fsm: RTL and testbench



---
 rtl/lock_pkg.sv | 28 ++
 rtl/lock_if.sv | 20 ++
 rtl/lock_timer.sv | 23 ++
 rtl/lock_fsm.sv | 126 ++++++++++++
 tb/tb_lock_fsm.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/lock_pkg.sv
// Shared definitions for the digital lock: display symbol codes, FSM state
// encoding and LED bit positions (also imported by the display mux).
package lock_pkg;

    typedef enum logic [2:0] {
        ST_LOCKED,
        ST_CHECK,
        ST_OPEN,
        ST_ERROR,
        ST_LOCKOUT
    } state_t;

    localparam logic [3:0] SYM_K     = 4'd8;
    localparam logic [3:0] SYM_C     = 4'd9;
    localparam logic [3:0] SYM_O     = 4'd10;
    localparam logic [3:0] SYM_L     = 4'd11;
    localparam logic [3:0] SYM_N     = 4'd12;
    localparam logic [3:0] SYM_U     = 4'd13;
    localparam logic [3:0] SYM_E     = 4'd6;
    localparam logic [3:0] SYM_R     = 4'd14;
    localparam logic [3:0] SYM_BLANK = 4'd15;

    localparam int LED_OPEN    = 0;
    localparam int LED_ERROR   = 1;
    localparam int LED_LOCKOUT = 2;
    localparam int LED_ENTRY   = 3;

endpackage

// File: rtl/lock_if.sv
// Key/code inputs and display outputs of the lock FSM; the FSM is the slave,
// whoever drives keys and reads the display is the master.
interface lock_if;
    logic       key_valid;
    logic [2:0] key_digit;
    logic       lock_btn;
    logic       password;
    logic [2:0] code0, code1, code2;
    logic [3:0] hex10, hex11, hex12, hex13, hex14, hex15;
    logic [3:0] led1;

    modport master (
        output key_valid, key_digit, lock_btn, password, code0, code1, code2,
        input  hex10, hex11, hex12, hex13, hex14, hex15, led1
    );
    modport slave (
        input  key_valid, key_digit, lock_btn, password, code0, code1, code2,
        output hex10, hex11, hex12, hex13, hex14, hex15, led1
    );
endinterface

// File: rtl/lock_timer.sv
// Loadable 32-bit down-counter with a zero flag; it parks at zero rather than
// wrapping, so a fresh load is needed for every timed state.
module lock_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic        dec,
    output logic        zero
);
    logic [31:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != 32'd0)
            cnt <= cnt - 32'd1;
    end

    assign zero = (cnt == 32'd0);
endmodule

// File: rtl/lock_fsm.sv
// Digital lock core: collects three key digits, checks them against the stored
// code and drives registered symbol codes / LEDs for the display mux.
module lock_fsm
    import lock_pkg::*;
#(
    parameter int unsigned ERR_CYCLES     = 50000000,
    parameter int unsigned LOCKOUT_CYCLES = 250000000,
    parameter int unsigned OPEN_CYCLES    = 500000000,
    parameter int unsigned MAX_FAIL       = 3
) (
    input  logic   clk,
    input  logic   reset,
    lock_if.slave  bus
);
    state_t          state, nstate;
    logic [1:0]      count, ncount;
    logic [2:0]      fails, nfails;
    logic [2:0][2:0] entry, nentry;
    logic            tload, tdec, tzero;
    logic [31:0]     tval;

    lock_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tload),
        .load_val (tval),
        .dec      (tdec),
        .zero     (tzero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_LOCKED;
            count <= '0;
            fails <= '0;
            entry <= '0;
        end else begin
            state <= nstate;
            count <= ncount;
            fails <= nfails;
            entry <= nentry;
        end
    end

    always_comb begin
        nstate = state;
        ncount = count;
        nfails = fails;
        nentry = entry;
        tload  = 1'b0;
        tval   = '0;
        tdec   = (state == ST_OPEN) || (state == ST_ERROR) || (state == ST_LOCKOUT);
        // Password mode wins over everything except an active lockout.
        if (bus.password && state != ST_LOCKOUT) begin
            nstate = ST_LOCKED;
            ncount = '0;
            nfails = '0;
        end else begin
            case (state)
                ST_LOCKED: begin
                    if (!bus.lock_btn && bus.key_valid && bus.key_digit <= 3'd4) begin
                        for (int i = 0; i < 3; i++)
                            if (count == 2'(i)) nentry[i] = bus.key_digit;
                        ncount = count + 2'd1;
                        if (count == 2'd2) nstate = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    ncount = '0;
                    tload  = 1'b1;
                    if (entry[0] == bus.code0 && entry[1] == bus.code1 && entry[2] == bus.code2) begin
                        nfails = '0;
                        tval   = 32'(OPEN_CYCLES - 1);
                        nstate = ST_OPEN;
                    end else begin
                        nfails = fails + 3'd1;
                        if (fails + 3'd1 == 3'(MAX_FAIL)) begin
                            tval   = 32'(LOCKOUT_CYCLES - 1);
                            nstate = ST_LOCKOUT;
                        end else begin
                            tval   = 32'(ERR_CYCLES - 1);
                            nstate = ST_ERROR;
                        end
                    end
                end
                ST_OPEN:    if (bus.lock_btn || tzero) nstate = ST_LOCKED;
                ST_ERROR:   if (tzero) nstate = ST_LOCKED;
                ST_LOCKOUT: if (tzero) begin
                    nstate = ST_LOCKED;
                    nfails = '0;
                end
                default:    nstate = ST_LOCKED;
            endcase
        end
    end

    // Display lags the state by one cycle; CHECK keeps whatever was shown.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {bus.hex15, bus.hex14, bus.hex13, bus.hex12, bus.hex11, bus.hex10} <=
                {SYM_L, SYM_O, SYM_C, SYM_K, SYM_BLANK, 4'd0};
            bus.led1 <= '0;
        end else begin
            case (state)
                ST_LOCKED:
                    {bus.hex15, bus.hex14, bus.hex13, bus.hex12, bus.hex11, bus.hex10} <=
                        {SYM_L, SYM_O, SYM_C, SYM_K, SYM_BLANK, {2'b00, count}};
                ST_OPEN:
                    {bus.hex15, bus.hex14, bus.hex13, bus.hex12, bus.hex11, bus.hex10} <=
                        {SYM_U, SYM_N, SYM_L, SYM_O, SYM_C, SYM_K};
                ST_ERROR:
                    {bus.hex15, bus.hex14, bus.hex13, bus.hex12, bus.hex11, bus.hex10} <=
                        {SYM_E, SYM_R, SYM_R, SYM_BLANK, SYM_BLANK, 4'(MAX_FAIL) - {1'b0, fails}};
                ST_LOCKOUT:
                    {bus.hex15, bus.hex14, bus.hex13, bus.hex12, bus.hex11, bus.hex10} <=
                        {SYM_L, SYM_O, SYM_C, SYM_K, SYM_BLANK, SYM_BLANK};
                default: ;
            endcase
            bus.led1                <= '0;
            bus.led1[LED_OPEN]      <= (state == ST_OPEN);
            bus.led1[LED_ERROR]     <= (state == ST_ERROR);
            bus.led1[LED_LOCKOUT]   <= (state == ST_LOCKOUT);
            bus.led1[LED_ENTRY]     <= (state == ST_LOCKED) && (count != 2'd0);
        end
    end
endmodule

// File: tb/tb_lock_fsm.sv
// Bench for lock_fsm: directed scenarios then random keys, each cycle checked
// against a behavioural model of the lock with a one-cycle display lag.
module tb_lock_fsm;
    localparam int ERR = 4, LCK = 8, OPN = 10, MAXF = 3;
    localparam int M_LOCKED = 0, M_CHECK = 1, M_OPEN = 2, M_ERROR = 3, M_LOCKOUT = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    lock_if bus();

    lock_fsm #(.ERR_CYCLES(ERR), .LOCKOUT_CYCLES(LCK), .OPEN_CYCLES(OPN), .MAX_FAIL(MAXF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;
    int st, cnt, fails, left;
    int ent[3];
    int code[3] = '{2, 0, 4};
    logic [23:0] exp_disp;
    logic [3:0]  exp_led;

    function automatic logic [23:0] disp_of(int s, int c, int f);
        case (s)
            M_OPEN:    return {4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd8};
            M_ERROR:   return {4'd6, 4'd14, 4'd14, 4'd15, 4'd15, 4'(MAXF - f)};
            M_LOCKOUT: return {4'd11, 4'd10, 4'd9, 4'd8, 4'd15, 4'd15};
            default:   return {4'd11, 4'd10, 4'd9, 4'd8, 4'd15, 4'(c)};
        endcase
    endfunction

    function automatic logic [3:0] led_of(int s, int c);
        if (s == M_OPEN)    return 4'b0001;
        if (s == M_ERROR)   return 4'b0010;
        if (s == M_LOCKOUT) return 4'b0100;
        if (s == M_LOCKED && c > 0) return 4'b1000;
        return 4'b0000;
    endfunction

    task automatic model_reset();
        st = M_LOCKED; cnt = 0; fails = 0; left = 0;
        exp_disp = disp_of(M_LOCKED, 0, 0);
        exp_led  = 4'b0000;
    endtask

    task automatic model_edge(input logic kv, input int kd, input logic lb, input logic pw);
        if (pw && st != M_LOCKOUT) begin
            st = M_LOCKED; cnt = 0; fails = 0;
        end else if (st == M_LOCKED) begin
            if (kv && !lb && kd <= 4) begin
                ent[cnt] = kd;
                cnt++;
                if (cnt == 3) st = M_CHECK;
            end
        end else if (st == M_CHECK) begin
            cnt = 0;
            if (ent == code) begin
                fails = 0; st = M_OPEN; left = OPN;
            end else begin
                fails++;
                if (fails == MAXF) begin st = M_LOCKOUT; left = LCK; end
                else begin st = M_ERROR; left = ERR; end
            end
        end else if (st == M_OPEN && lb) begin
            st = M_LOCKED;
        end else begin
            left--;
            if (left == 0) begin
                if (st == M_LOCKOUT) fails = 0;
                st = M_LOCKED;
            end
        end
    endtask

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] expv);
        ntests++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step(input logic kv, input int kd, input logic lb, input logic pw);
        bus.key_valid = kv;
        bus.key_digit = 3'(kd);
        bus.lock_btn  = lb;
        bus.password  = pw;
        if (st != M_CHECK) exp_disp = disp_of(st, cnt, fails);
        exp_led = led_of(st, cnt);
        @(posedge clk);
        model_edge(kv, kd, lb, pw);
        #1;
        check("disp", {bus.hex15, bus.hex14, bus.hex13, bus.hex12, bus.hex11, bus.hex10}, exp_disp);
        check("led", {20'd0, bus.led1}, {20'd0, exp_led});
        bus.key_valid = 1'b0;
        bus.lock_btn  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic keys(input int a, input int b, input int c);
        step(1'b1, a, 1'b0, 1'b0);
        step(1'b1, b, 1'b0, 1'b0);
        step(1'b1, c, 1'b0, 1'b0);
    endtask

    initial begin
        bus.key_valid = 1'b0; bus.key_digit = '0; bus.lock_btn = 1'b0; bus.password = 1'b0;
        bus.code0 = 3'd2; bus.code1 = 3'd0; bus.code2 = 3'd4;
        model_reset();
        #12;
        check("reset_disp", {bus.hex15, bus.hex14, bus.hex13, bus.hex12, bus.hex11, bus.hex10}, exp_disp);
        check("reset_led", {20'd0, bus.led1}, 24'd0);
        reset = 1'b0;
        idle(2);

        // correct code, then auto-relock
        keys(2, 0, 4);
        idle(14);
        // wrong code -> ERROR
        keys(1, 1, 1);
        idle(7);
        // two more failures -> LOCKOUT, keys ignored inside it, then correct code
        keys(3, 3, 3);
        idle(7);
        keys(0, 0, 0);
        idle(2);
        keys(2, 0, 4);
        idle(6);
        keys(2, 0, 4);
        idle(3);
        // lock_btn wins over a key in OPEN
        step(1'b1, 2, 1'b1, 1'b0);
        idle(2);
        // out-of-range digit ignored
        step(1'b1, 1, 1'b0, 1'b0);
        step(1'b1, 6, 1'b0, 1'b0);
        step(1'b1, 7, 1'b0, 1'b0);
        idle(1);
        step(1'b1, 3, 1'b0, 1'b0);
        idle(6);
        // password clears an entry in progress and the fail count
        keys(1, 2, 3);
        idle(6);
        step(1'b1, 2, 1'b0, 1'b0);
        step(1'b1, 0, 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b1);
        step(1'b1, 2, 1'b0, 1'b1);
        step(1'b1, 0, 1'b0, 1'b1);
        idle(1);
        keys(1, 1, 1);
        idle(6);
        // asynchronous reset in the middle of OPEN
        keys(2, 0, 4);
        idle(4);
        #2 reset = 1'b1;
        model_reset();
        #1;
        check("async_rst_disp", {bus.hex15, bus.hex14, bus.hex13, bus.hex12, bus.hex11, bus.hex10}, exp_disp);
        check("async_rst_led", {20'd0, bus.led1}, 24'd0);
        #2 reset = 1'b0;
        idle(2);

        for (int i = 0; i < 600; i++) begin
            int d;
            logic kv, lb, pw;
            kv = ($urandom_range(0, 99) < 60);
            d  = ($urandom_range(0, 2) != 0 && cnt < 3) ? code[cnt] : int'($urandom_range(0, 7));
            lb = ($urandom_range(0, 19) == 0);
            pw = ($urandom_range(0, 59) == 0);
            step(kv, d, lb, pw);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
